// File: rtl/fp32_pkg.sv
// +----------------------------------------------------------------------+
// | fp32_pkg : shared binary32 constants, field layout and helpers       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fp32_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_BIAS   = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic [31:0] fp32_signed_inf(input logic s);
    return FP32_POS_INF | {s, 31'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_lzc.sv
// +----------------------------------------------------------------------+
// | fp32_lzc : 24-bit leading-zero counter (all-zero input returns 24)   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp32_lzc (
  input  logic [23:0] val_i,
  output logic [4:0]  lz_o
);

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    lz_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (val_i[i]) lz_o = 5'(23 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_adder.sv
// +----------------------------------------------------------------------+
// | fp32_adder : binary32 adder, truncating, one output register stage   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp32_adder
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] out
);

  localparam logic signed [9:0] EXP_MAX = 10'(2 * FP32_BIAS + 1);

  fp32_t a_s, b_s;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic [23:0] ma, mb, m_big, m_small, m_shift, diff_m;
  logic [22:0] norm_m, mant_r;
  logic [7:0]  e_big, e_small, e_diff;
  logic [24:0] sum;
  logic [4:0]  lz;
  logic        s_big, s_r;
  logic signed [9:0] exp_r;
  logic [31:0] res_d, out_q;
  logic        out_valid_q;

  assign a_s    = a;
  assign b_s    = b;
  assign a_nan  = (a_s.exp == 8'hFF) && (a_s.frac != '0);
  assign b_nan  = (b_s.exp == 8'hFF) && (b_s.frac != '0);
  assign a_inf  = (a_s.exp == 8'hFF) && (a_s.frac == '0);
  assign b_inf  = (b_s.exp == 8'hFF) && (b_s.frac == '0);
  assign a_zero = (a_s.exp == 8'h00);
  assign b_zero = (b_s.exp == 8'h00);

  assign ma = {1'b1, a_s.frac};
  assign mb = {1'b1, b_s.frac};

  // Mantissa tie-break keeps the result bit-exact under operand swap.
  assign a_big   = (a_s.exp > b_s.exp) || ((a_s.exp == b_s.exp) && (ma >= mb));
  assign m_big   = a_big ? ma : mb;
  assign m_small = a_big ? mb : ma;
  assign e_big   = a_big ? a_s.exp : b_s.exp;
  assign e_small = a_big ? b_s.exp : a_s.exp;
  assign s_big   = a_big ? a_s.sign : b_s.sign;
  assign e_diff  = e_big - e_small;
  assign m_shift = (e_diff >= 8'd24) ? 24'd0 : (m_small >> e_diff);

  assign sum    = {1'b0, m_big} + {1'b0, m_shift};
  assign diff_m = m_big - m_shift;

  fp32_lzc u_lzc (
    .val_i (diff_m),
    .lz_o  (lz)
  );

  assign norm_m = 23'(diff_m << lz);

  always_comb begin
    res_d  = '0;
    s_r    = 1'b0;
    exp_r  = '0;
    mant_r = '0;
    if (a_nan || b_nan) begin
      res_d = FP32_QNAN;
    end else if (a_inf && b_inf && (a_s.sign != b_s.sign)) begin
      res_d = FP32_QNAN;
    end else if (a_inf) begin
      res_d = a;
    end else if (b_inf) begin
      res_d = b;
    end else if (a_zero && b_zero) begin
      res_d = {a_s.sign & b_s.sign, 31'b0};
    end else if (a_zero) begin
      res_d = b;
    end else if (b_zero) begin
      res_d = a;
    end else if (a_s.sign == b_s.sign) begin
      s_r = a_s.sign;
      if (sum[24]) begin
        mant_r = sum[23:1];
        exp_r  = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
        mant_r = sum[22:0];
        exp_r  = $signed({2'b00, e_big});
      end
      res_d = (exp_r >= EXP_MAX) ? fp32_signed_inf(s_r) : {s_r, exp_r[7:0], mant_r};
    end else if (diff_m == '0) begin
      res_d = '0;
    end else begin
      s_r    = s_big;
      mant_r = norm_m;
      exp_r  = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
      if (exp_r <= 10'sd0) res_d = {s_r, 31'b0};
      else                 res_d = {s_r, exp_r[7:0], mant_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) out_q <= res_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp32_adder.sv
// +----------------------------------------------------------------------+
// | tb_fp32_adder : scoreboard bench for fp32_adder                      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  fp32_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] exp_v);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    exp_q.push_back(exp_v);
    last_exp = exp_v;
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'h1, 32'h0);
      end else begin
        check_eq("result", out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_eq("reset_out", out, 32'h0);
    check_eq("reset_valid", {31'b0, out_valid}, 32'h0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    send(32'b0_10101010_10101010101010101010101, 32'b0_10101010_01010101010101010101010,
         32'b0_10101011_01111111111111111111111);
    send(32'h55555555, 32'h55555555, 32'b0_10101011_10101010101010101010101);
    send(32'b1_10001100_00011000010001100011111, 32'b0_10001101_11001010100011111000001,
         32'b0_10001101_00111110011011000110010);
    send(32'b1_10001100_00110001100101010101110, 32'b0_10001100_00110001100101010101110, 32'h0);
    send(32'b0_10001000_00001010000011111101100, 32'b0_10010000_11001101110111010111011,
         32'b0_10010000_11001110111001111000010);
    send(32'b0_10010000_11001101110111010111011, 32'b0_10001000_00001010000011111101100,
         32'b0_10010000_11001110111001111000010);
    send(32'h7F800000, 32'hFF800000, 32'h7FC00000);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000);
    send(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    send(32'h3F800000, 32'hFF800000, 32'hFF800000);
    send(32'h80000000, 32'h80000000, 32'h80000000);
    send(32'h00000000, 32'h80000000, 32'h00000000);
    send(32'h00000001, 32'h3F800000, 32'h3F800000);
    send(32'h80400000, 32'h80000000, 32'h80000000);
    send(32'h3F800000, 32'h3F800000, 32'h40000000);
    send(32'h3F800000, 32'hBF000000, 32'h3F000000);
    send(32'h3F800000, 32'h30800000, 32'h3F800000);
    send(32'h00C00000, 32'h80800000, 32'h00000000);
    send(32'h80C00000, 32'h00800000, 32'h80000000);
    send(32'h3F800000, 32'h40000000, 32'h40400000);

    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'h12345678;
    b        = 32'h3F800000;
    @(posedge clk);
    #2;
    check_eq("hold_valid", {31'b0, out_valid}, 32'h0);
    check_eq("hold_out", out, last_exp);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'h0);

    send(32'h3F800000, 32'h3F800000, 32'h40000000);
    @(posedge clk);
    #3;
    check_eq("pre_reset_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("async_reset_out", out, 32'h0);
    check_eq("async_reset_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
